// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl
// Brief    : Multi-cycle CPU control FSM (FETCH/DECODE/EXEC/MEM/WB/HALT)
//            with memory-ready stall, timeout and illegal-op detection.
//            Optional MULTICYCLE_CTRL_PERF_EN adds cycle/retire counters.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       clock_enable,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_read,
  output logic       mem_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src,
  output logic       mem_to_reg,
  output logic [3:0] alu_ctrl,
  output logic       illegal_op,
  output logic       bus_error
`ifdef MULTICYCLE_CTRL_PERF_EN
  ,
  output logic [31:0] cycle_count,
  output logic [31:0] instr_retired
`endif
);

  localparam logic [5:0] c_OP_RTYPE = 6'b000000;
  localparam logic [5:0] c_OP_LW    = 6'b100011;
  localparam logic [5:0] c_OP_SW    = 6'b101011;
  localparam logic [5:0] c_OP_ADDI  = 6'b001000;
  localparam logic [5:0] c_OP_BEQ   = 6'b000100;
  localparam logic [5:0] c_OP_J     = 6'b000010;

  localparam logic [5:0] c_FN_ADD = 6'b100000;
  localparam logic [5:0] c_FN_SUB = 6'b100010;
  localparam logic [5:0] c_FN_AND = 6'b100100;
  localparam logic [5:0] c_FN_OR  = 6'b100101;
  localparam logic [5:0] c_FN_SLT = 6'b101010;

  localparam logic [3:0] c_ALU_AND = 4'b0000;
  localparam logic [3:0] c_ALU_OR  = 4'b0001;
  localparam logic [3:0] c_ALU_ADD = 4'b0010;
  localparam logic [3:0] c_ALU_SUB = 4'b0110;
  localparam logic [3:0] c_ALU_SLT = 4'b0111;

  localparam logic [3:0] c_TIMEOUT_LAST = 4'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t     r_state;
  logic [5:0] r_opcode;
  logic [5:0] r_funct;
  logic [3:0] r_wait_cnt;
  logic       r_illegal;
  logic       r_bus_err;

  logic       w_rtype, w_lw, w_sw, w_addi, w_beq;
  logic       w_op_known, w_op_jump;
  logic       w_funct_ok;
  logic [3:0] w_funct_alu;
  logic       w_wait_state, w_timeout;
  logic       w_mem_read, w_mem_write, w_pc_write, w_ir_write, w_reg_write;

  // Classes of the instruction latched at the end of DECODE
  assign w_rtype = (r_opcode == c_OP_RTYPE);
  assign w_lw    = (r_opcode == c_OP_LW);
  assign w_sw    = (r_opcode == c_OP_SW);
  assign w_addi  = (r_opcode == c_OP_ADDI);
  assign w_beq   = (r_opcode == c_OP_BEQ);

  // DECODE steers on the live IR fields, before they are latched
  assign w_op_known = (opcode == c_OP_RTYPE) || (opcode == c_OP_LW) ||
                      (opcode == c_OP_SW) || (opcode == c_OP_ADDI) ||
                      (opcode == c_OP_BEQ);
  assign w_op_jump  = (opcode == c_OP_J);

  always_comb begin
    w_funct_alu = c_ALU_AND;
    w_funct_ok  = 1'b1;
    case (r_funct)
      c_FN_ADD: w_funct_alu = c_ALU_ADD;
      c_FN_SUB: w_funct_alu = c_ALU_SUB;
      c_FN_AND: w_funct_alu = c_ALU_AND;
      c_FN_OR:  w_funct_alu = c_ALU_OR;
      c_FN_SLT: w_funct_alu = c_ALU_SLT;
      default:  w_funct_ok  = 1'b0;
    endcase
  end

  assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEM);
  assign w_timeout    = w_wait_state && !mem_ready && (r_wait_cnt == c_TIMEOUT_LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_FETCH;
      r_opcode   <= 6'd0;
      r_funct    <= 6'd0;
      r_wait_cnt <= 4'd0;
      r_illegal  <= 1'b0;
      r_bus_err  <= 1'b0;
    end else if (clock_enable) begin
      r_wait_cnt <= (w_wait_state && !mem_ready && !w_timeout) ? r_wait_cnt + 4'd1 : 4'd0;
      if (w_timeout) begin
        r_bus_err <= 1'b1;
        r_state   <= S_HALT;
      end else begin
        case (r_state)
          S_FETCH: if (mem_ready) r_state <= S_DECODE;
          S_DECODE: begin
            r_opcode <= opcode;
            r_funct  <= funct;
            if (w_op_known) begin
              r_state <= S_EXEC;
            end else if (w_op_jump) begin
              r_state <= S_FETCH;
            end else begin
              r_illegal <= 1'b1;
              r_state   <= S_HALT;
            end
          end
          S_EXEC: begin
            if (w_rtype) begin
              if (w_funct_ok) begin
                r_state <= S_WB;
              end else begin
                r_illegal <= 1'b1;
                r_state   <= S_HALT;
              end
            end else if (w_lw || w_sw) begin
              r_state <= S_MEM;
            end else if (w_addi) begin
              r_state <= S_WB;
            end else begin
              r_state <= S_FETCH;
            end
          end
          S_MEM:   if (mem_ready) r_state <= w_lw ? S_WB : S_FETCH;
          S_WB:    r_state <= S_FETCH;
          S_HALT:  r_state <= S_HALT;
          default: r_state <= S_HALT;
        endcase
      end
    end
  end

  always_comb begin
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    w_pc_write  = 1'b0;
    w_ir_write  = 1'b0;
    w_reg_write = 1'b0;
    pc_src      = 2'b00;
    reg_dst     = 1'b0;
    alu_src     = 1'b0;
    mem_to_reg  = 1'b0;
    alu_ctrl    = c_ALU_AND;
    case (r_state)
      S_FETCH: begin
        w_mem_read = 1'b1;
        if (mem_ready) begin
          w_ir_write = 1'b1;
          w_pc_write = 1'b1;
        end
      end
      S_DECODE: begin
        if (w_op_jump) begin
          w_pc_write = 1'b1;
          pc_src     = 2'b10;
        end
      end
      S_EXEC: begin
        if (w_rtype) begin
          alu_ctrl = w_funct_alu;
        end else if (w_lw || w_sw || w_addi) begin
          alu_src  = 1'b1;
          alu_ctrl = c_ALU_ADD;
        end else if (w_beq) begin
          alu_ctrl = c_ALU_SUB;
          if (zero) begin
            w_pc_write = 1'b1;
            pc_src     = 2'b01;
          end
        end
      end
      S_MEM: begin
        w_mem_read  = w_lw;
        w_mem_write = w_sw;
      end
      S_WB: begin
        w_reg_write = 1'b1;
        reg_dst     = w_rtype;
        mem_to_reg  = w_lw;
      end
      default: ;
    endcase
  end

  // reset_n gating keeps FETCH decode quiet while reset is held
  assign mem_read   = w_mem_read  & reset_n;
  assign mem_write  = w_mem_write & clock_enable;
  assign pc_write   = w_pc_write  & clock_enable & reset_n;
  assign ir_write   = w_ir_write  & clock_enable & reset_n;
  assign reg_write  = w_reg_write & clock_enable;
  assign illegal_op = r_illegal;
  assign bus_error  = r_bus_err;

`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [31:0] r_cycle_count;
  logic [31:0] r_instr_retired;
  logic        w_retire;

  // Every path back into FETCH from DECODE/EXEC/MEM/WB completes an instruction
  assign w_retire = ((r_state == S_DECODE) && w_op_jump) ||
                    ((r_state == S_EXEC) && w_beq) ||
                    ((r_state == S_MEM) && w_sw && mem_ready) ||
                    (r_state == S_WB);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cycle_count   <= 32'd0;
      r_instr_retired <= 32'd0;
    end else if (clock_enable) begin
      if (r_state != S_HALT) r_cycle_count <= r_cycle_count + 32'd1;
      if (w_retire) r_instr_retired <= r_instr_retired + 32'd1;
    end
  end

  assign cycle_count   = r_cycle_count;
  assign instr_retired = r_instr_retired;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// Directed bench for multicycle_ctrl: per-cycle expected output vectors go
// through a scoreboard queue and are compared at the falling edge.
module tb_multicycle_ctrl;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       clock_enable;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       mem_read, mem_write, pc_write, ir_write;
  logic [1:0] pc_src;
  logic       reg_dst, reg_write, alu_src, mem_to_reg;
  logic [3:0] alu_ctrl;
  logic       illegal_op, bus_error;
`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [31:0] cycle_count, instr_retired;
`endif

  always #5 clock = ~clock;

  multicycle_ctrl #(.MEM_TIMEOUT(15)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .clock_enable (clock_enable),
    .opcode       (opcode),
    .funct        (funct),
    .zero         (zero),
    .mem_ready    (mem_ready),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .pc_write     (pc_write),
    .pc_src       (pc_src),
    .ir_write     (ir_write),
    .reg_dst      (reg_dst),
    .reg_write    (reg_write),
    .alu_src      (alu_src),
    .mem_to_reg   (mem_to_reg),
    .alu_ctrl     (alu_ctrl),
    .illegal_op   (illegal_op),
    .bus_error    (bus_error)
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    .cycle_count  (cycle_count),
    .instr_retired(instr_retired)
`endif
  );

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];
  string       tag_q[$];

  logic [15:0] obs;
  assign obs = {mem_read, mem_write, pc_write, pc_src, ir_write, reg_dst, reg_write,
                alu_src, mem_to_reg, alu_ctrl, illegal_op, bus_error};

  function automatic logic [15:0] ov(input logic mr, input logic mw, input logic pw,
                                     input logic [1:0] ps, input logic iw, input logic rd,
                                     input logic rw, input logic as, input logic m2r,
                                     input logic [3:0] ac, input logic ill, input logic be);
    return {mr, mw, pw, ps, iw, rd, rw, as, m2r, ac, ill, be};
  endfunction

  // Fields: mem_read mem_write pc_write pc_src ir_write reg_dst reg_write alu_src mem_to_reg alu_ctrl ill be
  localparam logic [15:0] E_NONE      = 16'h0000;
  logic [15:0] e_fetch_rdy, e_fetch_wait, e_fetch_gated, e_exec_imm, e_beq_t, e_beq_n;
  logic [15:0] e_mem_lw, e_mem_sw, e_wb_r, e_wb_lw, e_wb_addi, e_dec_j, e_ill, e_bus;

  // One clock of directed stimulus: inputs are already driven, expected pushed,
  // checked at the falling edge, then the bench moves just past the next rise.
  task automatic step(input string tag, input logic [15:0] e);
    logic [15:0] ex;
    string       t;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clock);
    ex = exp_q.pop_front();
    t  = tag_q.pop_front();
    checks++;
    assert (obs === ex) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", t, obs, ex);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic check32(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  logic [5:0] fn_tab[5];
  logic [3:0] alu_tab[5];

  initial begin
    e_fetch_rdy   = ov(1,0,1,2'b00,1,0,0,0,0,4'b0000,0,0);
    e_fetch_wait  = ov(1,0,0,2'b00,0,0,0,0,0,4'b0000,0,0);
    e_fetch_gated = e_fetch_wait;
    e_exec_imm    = ov(0,0,0,2'b00,0,0,0,1,0,4'b0010,0,0);
    e_beq_t       = ov(0,0,1,2'b01,0,0,0,0,0,4'b0110,0,0);
    e_beq_n       = ov(0,0,0,2'b00,0,0,0,0,0,4'b0110,0,0);
    e_mem_lw      = ov(1,0,0,2'b00,0,0,0,0,0,4'b0000,0,0);
    e_mem_sw      = ov(0,1,0,2'b00,0,0,0,0,0,4'b0000,0,0);
    e_wb_r        = ov(0,0,0,2'b00,0,1,1,0,0,4'b0000,0,0);
    e_wb_lw       = ov(0,0,0,2'b00,0,0,1,0,1,4'b0000,0,0);
    e_wb_addi     = ov(0,0,0,2'b00,0,0,1,0,0,4'b0000,0,0);
    e_dec_j       = ov(0,0,1,2'b10,0,0,0,0,0,4'b0000,0,0);
    e_ill         = ov(0,0,0,2'b00,0,0,0,0,0,4'b0000,1,0);
    e_bus         = ov(0,0,0,2'b00,0,0,0,0,0,4'b0000,0,1);
    fn_tab  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    alu_tab = '{4'b0010,   4'b0110,   4'b0000,   4'b0001,   4'b0111};

    reset_n = 1'b0; clock_enable = 1'b1; opcode = 6'd0; funct = 6'd0;
    zero = 1'b0; mem_ready = 1'b1;
    @(posedge clock); #1;
    step("reset_quiet", E_NONE);
    reset_n = 1'b1;

    // R-type: every supported funct
    for (int i = 0; i < 5; i++) begin
      opcode = 6'b000000; funct = fn_tab[i];
      step("r_fetch",  e_fetch_rdy);
      step("r_decode", E_NONE);
      step("r_exec",   ov(0,0,0,2'b00,0,0,0,0,0,alu_tab[i],0,0));
      step("r_wb",     e_wb_r);
    end

    // lw with three wait states in MEM
    opcode = 6'b100011;
    step("lw_fetch",  e_fetch_rdy);
    step("lw_decode", E_NONE);
    step("lw_exec",   e_exec_imm);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) step("lw_mem_wait", e_mem_lw);
    mem_ready = 1'b1;
    step("lw_mem_rdy", e_mem_lw);
    step("lw_wb",      e_wb_lw);

    // addi
    opcode = 6'b001000;
    step("addi_fetch",  e_fetch_rdy);
    step("addi_decode", E_NONE);
    step("addi_exec",   e_exec_imm);
    step("addi_wb",     e_wb_addi);

    // beq taken then not taken
    opcode = 6'b000100; zero = 1'b1;
    step("beqt_fetch",  e_fetch_rdy);
    step("beqt_decode", E_NONE);
    step("beqt_exec",   e_beq_t);
    zero = 1'b0;
    step("beqn_fetch",  e_fetch_rdy);
    step("beqn_decode", E_NONE);
    step("beqn_exec",   e_beq_n);

    // j
    opcode = 6'b000010;
    step("j_fetch",  e_fetch_rdy);
    step("j_decode", e_dec_j);

    // sw with clock_enable dropped in MEM, plus a gated FETCH
    opcode = 6'b101011; clock_enable = 1'b0;
    step("fetch_ce0", e_fetch_gated);
    clock_enable = 1'b1;
    step("sw_fetch",  e_fetch_rdy);
    step("sw_decode", E_NONE);
    step("sw_exec",   e_exec_imm);
    mem_ready = 1'b0;
    step("sw_mem_wait", e_mem_sw);
    clock_enable = 1'b0; mem_ready = 1'b1;
    step("sw_mem_ce0a", E_NONE);
    step("sw_mem_ce0b", E_NONE);
    clock_enable = 1'b1; mem_ready = 1'b0;
    step("sw_mem_resume", e_mem_sw);
    mem_ready = 1'b1;
    step("sw_mem_rdy", e_mem_sw);

    // FETCH wait: 14 stalled cycles tolerated, 15 trips bus_error
    opcode = 6'b000010; mem_ready = 1'b0;
    for (int i = 0; i < 14; i++) step("fetch_wait14", e_fetch_wait);
    mem_ready = 1'b1;
    step("fetch_after14", e_fetch_rdy);
    step("j2_decode",     e_dec_j);
    mem_ready = 1'b0;
    for (int i = 0; i < 15; i++) step("fetch_wait15", e_fetch_wait);
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) step("bus_halt", e_bus);
    reset_n = 1'b0;
    step("bus_reset", E_NONE);
    reset_n = 1'b1;

    // Illegal opcode: HALT for 20 cycles, cleared by reset
    opcode = 6'b111111;
    step("ill_fetch",  e_fetch_rdy);
    step("ill_decode", E_NONE);
    for (int i = 0; i < 20; i++) step("ill_halt", e_ill);
    reset_n = 1'b0;
    step("ill_reset", E_NONE);
    reset_n = 1'b1;

    // add, lw, j with zero-wait memory: 11 cycles, 3 retired
    opcode = 6'b000000; funct = 6'b100000;
    step("p_add_f", e_fetch_rdy);
    step("p_add_d", E_NONE);
    step("p_add_e", ov(0,0,0,2'b00,0,0,0,0,0,4'b0010,0,0));
    step("p_add_w", e_wb_r);
    opcode = 6'b100011;
    step("p_lw_f", e_fetch_rdy);
    step("p_lw_d", E_NONE);
    step("p_lw_e", e_exec_imm);
    step("p_lw_m", e_mem_lw);
    step("p_lw_w", e_wb_lw);
    opcode = 6'b000010;
    step("p_j_f", e_fetch_rdy);
    step("p_j_d", e_dec_j);
`ifdef MULTICYCLE_CTRL_PERF_EN
    check32("cycle_count",   cycle_count,   32'd11);
    check32("instr_retired", instr_retired, 32'd3);
`endif
    step("p_final_fetch", e_fetch_rdy);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
